// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with synchroniser, start detect and baud timing
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote over rxd_s at every sample point.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RXD,
    input  logic                 Rx_En_Sig,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Done_Sig,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;
    logic                 sync1_q, rxd_s, prev_q;
    logic                 start_det;
    logic                 sample;
    logic                 ferr_now;

    assign start_det = prev_q & ~rxd_s;

`ifdef UART_RX_MAJORITY_EN
    // Two older samples plus the live rxd_s form the 3-sample voting window.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
    assign sample = rxd_s;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        rx_data_d  = rx_data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        ferr_now   = ferr_acc_q | ~sample;

        if (!Rx_En_Sig) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (start_det) begin
                        state_d    = START;
                        bit_d      = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = sample ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {sample, shift_q[DATA_BITS-1:1]};
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d      = '0;
                        bit_d      = '0;
                        // Even: error when total XOR is 1; odd: error when it is 0.
                        perr_acc_d = (^shift_q) ^ sample ^ (PARITY_MODE == 1);
                        state_d    = STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d      = '0;
                        ferr_acc_d = ferr_now;
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            state_d   = IDLE;
                            rx_data_d = shift_q;
                            perr_d    = perr_acc_q;
                            ferr_d    = ferr_now;
                            done_d    = 1'b1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            rx_data_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            sync1_q    <= 1'b1;
            rxd_s      <= 1'b1;
            prev_q     <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            rx_data_q  <= rx_data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
            sync1_q    <= RXD;
            rxd_s      <= sync1_q;
            prev_q     <= rxd_s;
        end
    end

    assign Rx_Data     = rx_data_q;
    assign Rx_Done_Sig = done_q;
    assign Parity_Err  = perr_q;
    assign Frame_Err   = ferr_q;
    assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (8N1 instance and 8E2 instance)
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       en_a = 1'b1, en_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       done_a, done_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0;
    int n0, t0;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .reset(reset), .RXD(rxd_a), .Rx_En_Sig(en_a), .Rx_Data(data_a),
        .Rx_Done_Sig(done_a), .Parity_Err(pe_a), .Frame_Err(fe_a), .Busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .reset(reset), .RXD(rxd_b), .Rx_En_Sig(en_b), .Rx_Data(data_b),
        .Rx_Done_Sig(done_b), .Parity_Err(pe_b), .Frame_Err(fe_b), .Busy(busy_b)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    task automatic hold_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; each bit lasts exactly CPB clocks.
    task automatic send_frame(input bit sel, input logic [8:0] data, input int par,
                              input logic s1, input logic s2, input int nstop,
                              input int glitch_bit, input int drop_bit);
        set_line(sel, 1'b0);
        hold_bit();
        for (int i = 0; i < 8; i++) begin
            set_line(sel, data[i]);
            if (i == drop_bit) begin
                repeat (CPB / 2) @(posedge clk);
                #1;
                check("abort_busy_before", busy_a, 1);
                en_a = 1'b0;
                @(posedge clk);
                #1;
                check("abort_busy_after", busy_a, 0);
                set_line(sel, 1'b1);
                return;
            end
            if (i == glitch_bit) begin
                repeat (CPB / 2) @(posedge clk);
                #1;
                set_line(sel, ~data[i]);
                @(posedge clk);
                #1;
                set_line(sel, data[i]);
                repeat (CPB / 2 - 1) @(posedge clk);
                #1;
            end else begin
                hold_bit();
            end
        end
        if (par >= 0) begin
            set_line(sel, par[0]);
            hold_bit();
        end
        set_line(sel, s1);
        hold_bit();
        if (nstop == 2) begin
            set_line(sel, s2);
            hold_bit();
        end
        set_line(sel, 1'b1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data_a", data_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_pe_a", pe_a, 0);
        check("rst_fe_a", fe_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_data_b", data_b, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 frame 0xA5
        n0 = done_cnt_a;
        t0 = cyc;
        send_frame(0, 9'h0A5, -1, 1'b1, 1'b1, 1, -1, -1);
        check("a5_data", data_a, 8'hA5);
        check("a5_pe", pe_a, 0);
        check("a5_fe", fe_a, 0);
        check("a5_pulses", done_cnt_a - n0, 1);
        check("a5_latency_window", ((done_cyc_a - t0) >= 150 && (done_cyc_a - t0) <= 158), 1);
        check("a5_busy_after", busy_a, 0);

        // Stop bit low: frame error but word and pulse still delivered
        n0 = done_cnt_a;
        send_frame(0, 9'h055, -1, 1'b0, 1'b1, 1, -1, -1);
        check("55_data", data_a, 8'h55);
        check("55_fe", fe_a, 1);
        check("55_pulses", done_cnt_a - n0, 1);

        n0 = done_cnt_a;
        send_frame(0, 9'h00F, -1, 1'b1, 1'b1, 1, -1, -1);
        check("0f_data", data_a, 8'h0F);
        check("0f_fe_cleared", fe_a, 0);
        check("0f_pulses", done_cnt_a - n0, 1);

        // False start: 4-clock low pulse
        n0 = done_cnt_a;
        rxd_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("fs_busy_in_start", busy_a, 1);
        repeat (20) @(posedge clk);
        #1;
        check("fs_busy_idle", busy_a, 0);
        check("fs_no_pulse", done_cnt_a - n0, 0);
        check("fs_data_kept", data_a, 8'h0F);
        check("fs_fe_kept", fe_a, 0);

        // Drop enable during data bit 3, then recover with 0x81
        n0 = done_cnt_a;
        send_frame(0, 9'h081, -1, 1'b1, 1'b1, 1, -1, 3);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_pulse", done_cnt_a - n0, 0);
        check("abort_data_kept", data_a, 8'h0F);
        en_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_frame(0, 9'h081, -1, 1'b1, 1'b1, 1, -1, -1);
        check("81_data", data_a, 8'h81);
        check("81_pulses", done_cnt_a - n0, 1);

        // Asynchronous reset in the middle of a frame
        rxd_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy", busy_a, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_data", data_a, 8'h00);
        rxd_a = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // One-clock high glitch at the middle of data bit 0 of 0x00
        n0 = done_cnt_a;
        send_frame(0, 9'h000, -1, 1'b1, 1'b1, 1, 0, -1);
`ifdef UART_RX_MAJORITY_EN
        check("glitch_data", data_a, 8'h00);
`else
        check("glitch_data", data_a, 8'h01);
`endif
        check("glitch_pulses", done_cnt_a - n0, 1);

        // Even parity, two stop bits
        check("b_quiet", done_cnt_b, 0);
        send_frame(1, 9'h03C, 1, 1'b1, 1'b1, 2, -1, -1);
        check("3c_p1_data", data_b, 8'h3C);
        check("3c_p1_pe", pe_b, 1);
        check("3c_p1_fe", fe_b, 0);
        send_frame(1, 9'h03C, 0, 1'b1, 1'b1, 2, -1, -1);
        check("3c_p0_pe", pe_b, 0);
        send_frame(1, 9'h0C3, 0, 1'b1, 1'b0, 2, -1, -1);
        check("c3_stop2_data", data_b, 8'hC3);
        check("c3_stop2_fe", fe_b, 1);
        check("c3_stop2_pe", pe_b, 0);
        check("b_pulses", done_cnt_b, 3);
        check("b_busy_after", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
